// File: rtl/p_fetch_ctrl.sv
// Fetch-stage controller: sequences the PC and the IF/ID register against a
// variable-latency instruction memory (req/ack), absorbing ID stalls and EX
// redirects with at most one fetch outstanding.
module p_fetch_ctrl #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0]     NOP_INST = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_target,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic [WIDTH-1:0] o_inst,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus_4,
  output logic             o_valid
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_pc4_q, if_pc4_d;
  logic             valid_q, valid_d;

  logic             req_c;
  logic             xfer_c;
  logic [WIDTH-1:0] redir_tgt_c;
  logic [WIDTH-1:0] pc_plus_4_c;

  assign req_c       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign xfer_c      = req_c && i_imem_ack;
  assign redir_tgt_c = i_redirect_target & ALIGN_MASK;
  assign pc_plus_4_c = pc_q + PC_STEP;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state: redirect beats stall beats normal flow
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (i_redirect)            state_d = xfer_c ? S_FETCH : S_DRAIN;
        else if (xfer_c && i_stall) state_d = S_HOLD;
      end
      S_HOLD:  if (i_redirect || !i_stall) state_d = S_FETCH;
      S_DRAIN: if (xfer_c) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Memory port: request held on the same address until the transfer completes
  always_comb begin
    o_imem_req  = req_c && !rst;
    o_imem_addr = pc_q;
  end

  // Datapath next values: PC, saved redirect target, skid buffer, IF/ID slot
  always_comb begin
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    inst_d      = inst_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    valid_d     = valid_q;
    if (i_redirect) begin
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
      skid_inst_d = '0;
      skid_pc_d   = '0;
      case (state_q)
        S_FETCH: begin
          if (xfer_c) pc_d  = redir_tgt_c;
          else        tgt_d = redir_tgt_c;
        end
        S_HOLD:  pc_d = redir_tgt_c;
        S_DRAIN: begin
          tgt_d = redir_tgt_c;
          if (xfer_c) pc_d = redir_tgt_c;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (xfer_c) begin
            pc_d = pc_plus_4_c;
            if (i_stall) begin
              skid_inst_d = i_imem_rdata;
              skid_pc_d   = pc_q;
            end else begin
              inst_d   = i_imem_rdata;
              if_pc_d  = pc_q;
              if_pc4_d = pc_plus_4_c;
              valid_d  = 1'b1;
            end
          end else if (!i_stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            inst_d   = skid_inst_q;
            if_pc_d  = skid_pc_q;
            if_pc4_d = skid_pc_q + PC_STEP;
            valid_d  = 1'b1;
          end
        end
        S_DRAIN: begin
          if (xfer_c) pc_d = tgt_q;
          if (!i_stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC & ALIGN_MASK;
      tgt_q       <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      inst_q      <= NOP_INST;
      if_pc_q     <= '0;
      if_pc4_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      inst_q      <= inst_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign o_inst      = inst_q;
  assign o_pc        = if_pc_q;
  assign o_pc_plus_4 = if_pc4_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_p_fetch_ctrl.sv
// Bench for p_fetch_ctrl: latency-programmable memory model, scoreboard of
// the PCs the ID stage is expected to accept, per-scenario inline checks.
module tb_p_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus_4;
  logic        o_valid;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int wait_cnt;
  logic force_ack = 1'b0;
  logic [31:0] sb[$];

  p_fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_stall           (i_stall),
    .i_redirect        (i_redirect),
    .i_redirect_target (i_redirect_target),
    .o_imem_req        (o_imem_req),
    .o_imem_addr       (o_imem_addr),
    .i_imem_ack        (i_imem_ack),
    .i_imem_rdata      (i_imem_rdata),
    .o_inst            (o_inst),
    .o_pc              (o_pc),
    .o_pc_plus_4       (o_pc_plus_4),
    .o_valid           (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: ack after `lat` waiting cycles of a held request
  always_comb begin
    i_imem_ack   = force_ack || (o_imem_req && (wait_cnt >= lat));
    i_imem_rdata = mem_f(o_imem_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                            wait_cnt <= 0;
    else if (o_imem_req && !i_imem_ack) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
  end

  // Scoreboard: every instruction ID accepts must be the next expected PC
  always @(negedge clk) begin
    if (!rst && o_valid && !i_stall && !i_redirect) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got pc=%h inst=%h required none", o_pc, o_inst);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (o_pc !== e || o_inst !== mem_f(e) || o_pc_plus_4 !== 32'(e + 32'd4)) begin
          bad++;
          $display("FAIL sb_inst got pc=%h inst=%h pc4=%h required pc=%h inst=%h pc4=%h",
                   o_pc, o_inst, o_pc_plus_4, e, mem_f(e), 32'(e + 32'd4));
        end
      end
    end
  end

  task automatic do_reset(input int l);
    rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_target = '0;
    force_ack = 1'b0; lat = l;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_imem_req, o_valid, o_inst, o_pc, o_pc_plus_4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got req=%b v=%b inst=%h pc=%h pc4=%h required 0 0 %h 0 0",
               o_imem_req, o_valid, o_inst, o_pc, o_pc_plus_4, NOP);
    end
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); #2; n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got remaining=%0d required 0", name, sb.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    @(negedge clk);
    total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL zw_first got v=%b req=%b addr=%h required 0 1 0", o_valid, o_imem_req, o_imem_addr);
    end
    @(negedge clk);
    total++;
    if ({o_valid, o_pc} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL zw_second got v=%b pc=%h required 1 0", o_valid, o_pc);
    end
    end_test("zero_wait");
  endtask

  task automatic test_wait_states();
    do_reset(3);
    sb.push_back(32'h0); sb.push_back(32'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL ws_wait%0d got req=%b addr=%h v=%b required 1 0 0", i, o_imem_req, o_imem_addr, o_valid);
      end
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({o_valid, o_pc, o_imem_addr} !== {1'b1, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL ws_capture got v=%b pc=%h addr=%h required 1 0 4", o_valid, o_pc, o_imem_addr);
    end
    end_test("wait_states");
  endtask

  task automatic test_stall();
    do_reset(0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    @(posedge clk); @(posedge clk); #1;
    i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_pc} !== {1'b1, 32'h4}) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b pc=%h required 1 4", i, o_valid, o_pc);
      end
      if (i > 0) begin
        total++;
        if (o_imem_req !== 1'b0) begin
          bad++;
          $display("FAIL stall_noreq%0d got req=%b required 0", i, o_imem_req);
        end
      end
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({o_valid, o_pc} !== {1'b1, 32'h8}) begin
      bad++;
      $display("FAIL stall_release got v=%b pc=%h required 1 8", o_valid, o_pc);
    end
    end_test("stall");
  endtask

  task automatic test_redirect_drain();
    do_reset(0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    sb.push_back(32'h100); sb.push_back(32'h104);
    repeat (4) @(posedge clk);
    #1;
    lat = 3; i_redirect = 1'b1; i_redirect_target = 32'h0000_0103;
    @(negedge clk);
    total++;
    if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h10}) begin
      bad++;
      $display("FAIL rd_out got req=%b addr=%h required 1 10", o_imem_req, o_imem_addr);
    end
    @(posedge clk); #1;
    i_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 32'h10, 1'b0}) begin
        bad++;
        $display("FAIL rd_drain%0d got req=%b addr=%h v=%b required 1 10 0", i, o_imem_req, o_imem_addr, o_valid);
      end
    end
    @(posedge clk); #1;
    lat = 0;
    @(negedge clk);
    total++;
    if ({o_imem_addr, o_valid} !== {32'h100, 1'b0}) begin
      bad++;
      $display("FAIL rd_target got addr=%h v=%b required 100 0", o_imem_addr, o_valid);
    end
    end_test("redirect_drain");
  endtask

  task automatic test_redirect_hold();
    do_reset(0);
    sb.push_back(32'h0); sb.push_back(32'h200); sb.push_back(32'h204);
    @(posedge clk); @(posedge clk); #1;
    i_stall = 1'b1;
    @(posedge clk); #1;
    i_redirect = 1'b1; i_redirect_target = 32'h0000_0200;
    @(negedge clk);
    total++;
    if (o_imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rh_hold got req=%b required 0", o_imem_req);
    end
    @(posedge clk); #1;
    i_redirect = 1'b0; i_stall = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_inst, o_imem_addr} !== {1'b0, NOP, 32'h200}) begin
      bad++;
      $display("FAIL rh_flush got v=%b inst=%h addr=%h required 0 %h 200", o_valid, o_inst, o_imem_addr, NOP);
    end
    end_test("redirect_hold");
  endtask

  task automatic test_reset_wrap();
    do_reset(0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    repeat (3) @(posedge clk);
    #1;
    lat = 5;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({o_imem_req, o_valid, o_inst, o_pc, o_pc_plus_4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL rw_async got req=%b v=%b inst=%h pc=%h pc4=%h required 0 0 %h 0 0",
               o_imem_req, o_valid, o_inst, o_pc, o_pc_plus_4, NOP);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rw_pre got remaining=%0d required 0", sb.size());
    end
    force_ack = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({o_imem_req, o_valid, o_pc} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL rw_lateack got req=%b v=%b pc=%h required 0 0 0", o_imem_req, o_valid, o_pc);
    end
    force_ack = 1'b0; lat = 0; rst = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
    @(negedge clk);
    total++;
    if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL rw_restart got req=%b addr=%h required 1 0", o_imem_req, o_imem_addr);
    end
    @(posedge clk); @(posedge clk); #1;
    i_redirect = 1'b1; i_redirect_target = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    i_redirect = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      bad++;
      $display("FAIL rw_align got v=%b addr=%h required 0 fffffffc", o_valid, o_imem_addr);
    end
    @(negedge clk);
    total++;
    if ({o_pc, o_pc_plus_4, o_imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL rw_wrap got pc=%h pc4=%h addr=%h required fffffffc 0 0", o_pc, o_pc_plus_4, o_imem_addr);
    end
    end_test("reset_wrap");
  endtask

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_target = '0;
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_reset_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

endmodule
